// File: rtl/gen_rr_arb_ctl.sv
// gen_rr_arb_ctl: round-robin arbiter that locks a one-hot grant on a shared
// resource until the owner pulses done. Re-arbitration happens in the done
// cycle so consecutive grants follow with no idle bubble. All outputs are
// registered.
module gen_rr_arb_ctl #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state, state_nx;
  logic [NUM_REQ-1:0] gnt_nx;
  logic [IDX_W-1:0]   idx_nx;
  logic               vld_nx;
  logic [IDX_W-1:0]   ptr, ptr_nx;
  logic [IDX_W-1:0]   rel_ptr;
  logic [IDX_W-1:0]   base;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               arb;

  // Priority pointer after releasing the current owner; wraps at NUM_REQ-1.
  always_comb begin
    rel_ptr = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Circular search for the first requester starting at the priority base.
  // In GRANT the base is the post-release pointer so the released owner
  // ends up last in the search order.
  always_comb begin
    int unsigned pos;
    logic [IDX_W-1:0] pos_idx;
    base      = (state == GRANT) ? rel_ptr : ptr;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    pos_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(base) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      pos_idx = IDX_W'(pos);
      if (!win_found && req[pos_idx]) begin
        win_found = 1'b1;
        win_idx   = pos_idx;
      end
    end
  end

  // Next-state and next-output logic; grant is held unless arbitrating.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    idx_nx   = gnt_idx;
    vld_nx   = gnt_vld;
    ptr_nx   = ptr;
    arb      = 1'b0;
    unique case (state)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (done) begin
          ptr_nx = rel_ptr;
          arb    = 1'b1;
        end
      end
    endcase
    if (arb) begin
      if (cfg_en && win_found) begin
        state_nx = GRANT;
        gnt_nx   = NUM_REQ'(1) << win_idx;
        idx_nx   = win_idx;
        vld_nx   = 1'b1;
      end else begin
        state_nx = IDLE;
        gnt_nx   = '0;
        idx_nx   = '0;
        vld_nx   = 1'b0;
      end
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      ptr     <= '0;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      gnt_idx <= idx_nx;
      gnt_vld <= vld_nx;
      ptr     <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_gen_rr_arb_ctl.sv
// Testbench for gen_rr_arb_ctl: a 4-requester and a 3-requester instance
// share stimulus; each is compared every cycle against a rule-level model.
module tb_gen_rr_arb_ctl;

  logic       clk;
  logic       rst_n;
  logic       cfg_en;
  logic [3:0] req;
  logic       done;

  logic [3:0] gnt4;
  logic [1:0] idx4;
  logic       vld4;
  logic [2:0] gnt3;
  logic [1:0] idx3;
  logic       vld3;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one set per instance.
  int m4_vld, m4_idx, m4_ptr;
  int m3_vld, m3_idx, m3_ptr;

  gen_rr_arb_ctl #(.NUM_REQ(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_en  (cfg_en),
    .req     (req),
    .done    (done),
    .gnt     (gnt4),
    .gnt_idx (idx4),
    .gnt_vld (vld4)
  );

  gen_rr_arb_ctl #(.NUM_REQ(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_en  (cfg_en),
    .req     (req[2:0]),
    .done    (done),
    .gnt     (gnt3),
    .gnt_idx (idx3),
    .gnt_vld (vld3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // First requester at or after base in circular order, -1 if none.
  function automatic int search(input int n, input int base, input logic [3:0] r);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (base + k) % n;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input int n, inout int vld, inout int idx, inout int ptr,
                            input logic en, input logic [3:0] r, input logic d);
    int w;
    if (vld == 0) begin
      w = en ? search(n, ptr, r) : -1;
      if (w >= 0) begin
        vld = 1;
        idx = w;
      end
    end else if (d) begin
      ptr = (idx + 1) % n;
      w = en ? search(n, ptr, r) : -1;
      if (w >= 0) begin
        idx = w;
      end else begin
        vld = 0;
        idx = 0;
      end
    end
  endtask

  task automatic check_all();
    check("gnt4",     32'(gnt4), m4_vld ? (32'd1 << m4_idx) : 32'd0);
    check("gnt_idx4", 32'(idx4), m4_vld ? 32'(m4_idx) : 32'd0);
    check("gnt_vld4", 32'(vld4), 32'(m4_vld));
    check("gnt3",     32'(gnt3), m3_vld ? (32'd1 << m3_idx) : 32'd0);
    check("gnt_idx3", 32'(idx3), m3_vld ? 32'(m3_idx) : 32'd0);
    check("gnt_vld3", 32'(vld3), 32'(m3_vld));
  endtask

  task automatic model_reset();
    m4_vld = 0; m4_idx = 0; m4_ptr = 0;
    m3_vld = 0; m3_idx = 0; m3_ptr = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // compare at the next falling edge.
  task automatic cycle(input logic en, input logic [3:0] r, input logic d);
    cfg_en = en;
    req    = r;
    done   = d;
    model_step(4, m4_vld, m4_idx, m4_ptr, en, r, d);
    model_step(3, m3_vld, m3_idx, m3_ptr, en, r & 4'b0111, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    cfg_en = 1'b0;
    req    = '0;
    done   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  int exp_seq4 [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n  = 1'b0;
    cfg_en = 1'b0;
    req    = '0;
    done   = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single request, held until done even after req drops.
    cycle(1'b1, 4'b0010, 1'b0);
    check("single_gnt", 32'(gnt4), 32'h2);
    cycle(1'b1, 4'b0000, 1'b0);
    check("single_hold", 32'(gnt4), 32'h2);
    cycle(1'b1, 4'b0000, 1'b1);
    check("single_release", 32'(vld4), 32'd0);
    cycle(1'b1, 4'b0000, 1'b0);

    // All requesting, done every cycle: strict rotation with no bubble.
    do_reset();
    cycle(1'b1, 4'b1111, 1'b0);
    check("rot_idx0", 32'(idx4), 32'(exp_seq4[0]));
    for (int i = 1; i < 6; i++) begin
      cycle(1'b1, 4'b1111, 1'b1);
      check("rot_idx", 32'(idx4), 32'(exp_seq4[i]));
      check("rot_vld", 32'(vld4), 32'd1);
    end

    // Owner 1 released (ptr=2); req=0011 wraps the search to requester 0.
    cycle(1'b1, 4'b0011, 1'b1);
    check("wrap_idx", 32'(idx4), 32'd0);
    cycle(1'b1, 4'b0011, 1'b1);
    check("wrap_next", 32'(idx4), 32'd1);

    // Disabled arbitration, then enable, then drop enable mid-grant.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b1111, 1'b0);
      check("dis_vld", 32'(vld4), 32'd0);
    end
    cycle(1'b1, 4'b1111, 1'b0);
    check("en_gnt", 32'(gnt4), 32'h1);
    cycle(1'b0, 4'b1111, 1'b0);
    check("en_hold", 32'(gnt4), 32'h1);
    cycle(1'b0, 4'b1111, 1'b1);
    check("dis_release", 32'(vld4), 32'd0);
    cycle(1'b0, 4'b1111, 1'b0);

    // done with no grant is ignored.
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);

    // 3-requester wrap: grant 2 then done returns to 0.
    do_reset();
    cycle(1'b1, 4'b0100, 1'b0);
    check("n3_idx2", 32'(idx3), 32'd2);
    cycle(1'b1, 4'b0111, 1'b1);
    check("n3_wrap", 32'(idx3), 32'd0);

    // Asynchronous reset while grant is active at index 2.
    do_reset();
    cycle(1'b1, 4'b1100, 1'b0);
    check("pre_rst_idx", 32'(idx4), 32'd2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_gnt", 32'(gnt4), 32'd0);
    check("async_idx", 32'(idx4), 32'd0);
    check("async_vld", 32'(vld4), 32'd0);
    check("async_vld3", 32'(vld3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 4'b1100, 1'b0);
    check("post_rst_idx", 32'(idx4), 32'd2);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic       en;
      logic [3:0] r;
      logic       d;
      en = ($urandom_range(0, 9) != 0);
      r  = 4'($urandom);
      d  = ($urandom_range(0, 2) == 0);
      cycle(en, r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gen_rr_arb_ctl.md
Name: gen_rr_arb_ctl

Overview:
- Round-robin arbiter/controller that shares one resource among NUM_REQ requesters.
- Issues a registered one-hot grant, plus its binary-encoded index for steering the shared datapath mux.
- The grant is held (locked) until the resource signals transaction completion (done).
- Supports back-to-back grants with no idle bubble, and a global enable for quiescing the resource.

Parameters:
- NUM_REQ, 4, number of requesters; legal range >= 2, not required to be a power of two.
- IDX_W, $clog2(NUM_REQ), localparam; width of encoded grant index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- cfg_en  input  1  arbitration enable; when low, no new grant is issued.
- req  input  NUM_REQ  request vector; bit i = requester i wants the resource.
- done  input  1  completion pulse from the resource/owner; releases the current grant.
- gnt  output  NUM_REQ  one-hot grant, registered; all-zero when no grant.
- gnt_idx  output  IDX_W  encoded index of the set bit in gnt; 0 when gnt_vld=0.
- gnt_vld  output  1  a grant is active (equals |gnt).

Behaviour:
- Single clock domain; rst_n is asynchronous active-low (assert async, deassert sync to clk by upstream).
- Reset values:
  - gnt=0, gnt_idx=0, gnt_vld=0.
  - state=IDLE.
  - priority pointer ptr=0 (requester 0 highest priority).
- State machine:
  - IDLE:
    - If cfg_en=1 and |req: pick the winner, which is the first i with req[i]=1 searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
    - On the next edge: gnt=onehot(winner), gnt_idx=winner, gnt_vld=1, state -> GRANT.
    - Otherwise remain IDLE with outputs zero.
  - GRANT:
    - Grant is held unchanged regardless of req changes, including the owner dropping req.
    - done is the sole release.
    - On done=1:
      - ptr_next = (gnt_idx + 1) mod NUM_REQ; wrap at NUM_REQ-1 -> 0, not at 2^IDX_W.
      - Same-cycle re-arbitration using ptr_next, masked by cfg_en.
      - If a winner exists: next edge loads the new grant (back-to-back, no bubble); state stays GRANT.
      - Else: next edge gnt=0, gnt_vld=0, gnt_idx=0, state -> IDLE.
    - The just-released requester gets the lowest priority in that re-arbitration; it can be re-granted only if no other req is set.
- Latency:
  - req -> gnt is 1 cycle from IDLE.
  - done -> next gnt is 1 cycle.
- ptr updates only on a done in GRANT; it does not change in IDLE.
- done while gnt_vld=0: ignored, no state or ptr change.
- cfg_en:
  - Sampled only when arbitrating.
  - Deassertion mid-grant does not revoke the grant; after done, the block goes to IDLE even if requests are pending.
  - Reassertion in IDLE grants on the following edge.
- Invariants (verification to assert):
  - gnt is one-hot or zero.
  - gnt_vld == |gnt.
  - gnt_idx equals the encoded gnt.
  - gnt only changes on the edge after done, or on a grant from IDLE.
- Reset mid-operation: all outputs and ptr clear immediately (asynchronously); the first post-reset grant searches from requester 0.
- Outputs are pure flops; no combinational path from req/done/cfg_en to any output.

Test Plan:
- NUM_REQ=4, cfg_en=1, req=0010 from cycle 0, done pulse at cycle 3 with req dropped -> cycle 1: gnt=0010, gnt_idx=1, gnt_vld=1, held through cycle 3; cycle 4: gnt=0000, gnt_vld=0.
- req=1111 held, done asserted every cycle -> gnt_idx sequence 0,1,2,3,0,1 on consecutive cycles; gnt_vld stays 1 with no bubble.
- Grant to idx 1 completes (ptr=2), then req=0011 -> next grant idx 0 (search wraps 2,3,0); requester 1 is not re-granted while 0 requests.
- cfg_en=0, req=1111 for 5 cycles -> gnt_vld=0 throughout; raise cfg_en -> next edge gnt=0001. Drop cfg_en during that grant, then done -> grant held until done, then gnt_vld=0 despite req=1111.
- NUM_REQ=3, req=111, grant at idx 2, done -> next grant idx 0, gnt_idx never reaches 3. done with gnt_vld=0 -> no change.
- Grant active at idx 2, assert rst_n=0 mid-cycle -> gnt/gnt_idx/gnt_vld go 0 immediately without a clock edge; after release with req=1100 -> grant idx 2 (search from ptr=0).
